seven_segment_seconds: RTL and testbench

//   Free-running decimal seconds counter that drives a common-cathode 7-segment display.
//   A prescaler divides clk down to a one-second tick, which advances a 0-9 digit.
//   The block is the core of the Tiny Tapeout user tile; the tile wrapper maps its pins 1:1.
//   A pin-selectable fast mode shortens the tick period so short simulations can see the digit advance.

---
 rtl/seg_pkg.sv | 20 ++
 rtl/seg7_decoder.sv | 26 ++
 rtl/seven_segment_seconds.sv | 73 +++++++
 tb/tb_seven_segment_seconds.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// ============================================================================
// Module  : seg_pkg
// Brief   : Segment lookup table and digit limit shared by the seconds display.
// Revision: 1.0
// ============================================================================
`default_nettype none

package seg_pkg;

   localparam logic [3:0] DIGIT_MAX = 4'd9;

   // Bit order gfedcba, bit0 = segment a, active-high (common cathode).
   localparam logic [6:0] SEG_LUT [0:9] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
      7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
   };

endpackage : seg_pkg

`default_nettype wire

// File: rtl/seg7_decoder.sv
// ============================================================================
// Module  : seg7_decoder
// Brief   : Combinational BCD digit to 7-segment decode; codes 10-15 blank.
// Revision: 1.0
// ============================================================================
`default_nettype none

module seg7_decoder
   import seg_pkg::*;
(
   input  logic [3:0] digit_i,
   output logic [6:0] seg_o
);

   always_comb begin
      seg_o = 7'h00;
      for (int i = 0; i <= int'(DIGIT_MAX); i++) begin
         if (digit_i == 4'(i)) begin
            seg_o = SEG_LUT[i];
         end
      end
   end

endmodule : seg7_decoder

`default_nettype wire

// File: rtl/seven_segment_seconds.sv
// ============================================================================
// Module  : seven_segment_seconds
// Brief   : Prescaled 0-9 seconds counter driving a 7-segment display + dp.
// Revision: 1.0
// ============================================================================
`default_nettype none

module seven_segment_seconds
   import seg_pkg::*;
#(
   parameter logic [23:0] MAX_COUNT = 24'd10_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ena,
   input  logic [7:0] ui_in,
   input  logic [7:0] uio_in,
   output logic [7:0] uo_out,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);

   logic [23:0] tick_cnt_q, tick_cnt_d;
   logic [3:0]  digit_q,    digit_d;
   logic        dp_q,       dp_d;

   logic [23:0] w_period;
   logic        w_tick;
   logic [6:0]  w_seg;
   logic        w_unused;

   assign w_unused = ^uio_in;

   // Comparing with >= lets a period shortened mid-count tick on the next edge
   // instead of running the counter up to its 24-bit wrap.
   assign w_period = ui_in[0] ? ({17'd0, ui_in[7:1]} + 24'd1) : MAX_COUNT;
   assign w_tick   = (tick_cnt_q >= (w_period - 24'd1));

   always_comb begin
      tick_cnt_d = tick_cnt_q + 24'd1;
      digit_d    = digit_q;
      dp_d       = dp_q;
      if (w_tick) begin
         tick_cnt_d = 24'd0;
         digit_d    = (digit_q == DIGIT_MAX) ? 4'd0 : digit_q + 4'd1;
         dp_d       = ~dp_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tick_cnt_q <= 24'd0;
         digit_q    <= 4'd0;
         dp_q       <= 1'b0;
      end else if (ena) begin
         tick_cnt_q <= tick_cnt_d;
         digit_q    <= digit_d;
         dp_q       <= dp_d;
      end
   end

   seg7_decoder u_dec (
      .digit_i (digit_q),
      .seg_o   (w_seg)
   );

   assign uo_out  = {dp_q, w_seg};
   assign uio_out = {4'b0000, digit_q};
   assign uio_oe  = 8'hFF;

endmodule : seven_segment_seconds

`default_nettype wire

// File: tb/tb_seven_segment_seconds.sv
// ============================================================================
// Module  : tb_seven_segment_seconds
// Brief   : Directed and randomized bench for seven_segment_seconds.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_seven_segment_seconds;

   localparam logic [23:0] TB_MAX = 24'd20;

   logic       clk = 1'b0;
   logic       rst;
   logic       ena;
   logic [7:0] ui_in;
   logic [7:0] uio_in;
   logic [7:0] uo_out;
   logic [7:0] uio_out;
   logic [7:0] uio_oe;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference state: clocks since last tick, and total ticks since reset.
   int m_cnt   = 0;
   int m_ticks = 0;

   logic [6:0] seg_ref [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

   always #5 clk = ~clk;

   seven_segment_seconds #(.MAX_COUNT(TB_MAX)) dut (
      .clk     (clk),
      .rst     (rst),
      .ena     (ena),
      .ui_in   (ui_in),
      .uio_in  (uio_in),
      .uo_out  (uo_out),
      .uio_out (uio_out),
      .uio_oe  (uio_oe)
   );

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: observed %02h expected %02h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic int period_of(input logic [7:0] ui);
      return ui[0] ? (int'(ui[7:1]) + 1) : int'(TB_MAX);
   endfunction

   function automatic logic [7:0] exp_uo();
      logic dp;
      dp = (m_ticks % 2) != 0;
      return {dp, seg_ref[m_ticks % 10]};
   endfunction

   function automatic logic [7:0] exp_uio();
      logic [7:0] d;
      d = 8'(m_ticks % 10);
      return d;
   endfunction

   // One clock: model advances on the rising edge, outputs compared at the falling edge.
   task automatic step(input string tag);
      @(posedge clk);
      if (rst) begin
         m_cnt   = 0;
         m_ticks = 0;
      end else if (ena) begin
         if (m_cnt + 1 >= period_of(ui_in)) begin
            m_cnt = 0;
            m_ticks++;
         end else begin
            m_cnt++;
         end
      end
      @(negedge clk);
      check({tag, "_uo"},  uo_out,  exp_uo());
      check({tag, "_uio"}, uio_out, exp_uio());
      check({tag, "_oe"},  uio_oe,  8'hFF);
   endtask

   task automatic run(input int n, input string tag);
      for (int i = 0; i < n; i++) step(tag);
   endtask

   task automatic do_reset(input logic [7:0] ui);
      rst   = 1'b1;
      ui_in = ui;
      step("reset");
      rst   = 1'b0;
   endtask

   initial begin
      rst    = 1'b1;
      ena    = 1'b1;
      ui_in  = 8'h00;
      uio_in = 8'($urandom);
      @(negedge clk);

      // Reset values
      step("rst");
      check("rst_uo_const",  uo_out,  8'h3F);
      check("rst_uio_const", uio_out, 8'h00);
      rst = 1'b0;

      // Fast period 4
      do_reset(8'h07);
      run(4, "p4a");
      check("p4_one", uo_out, 8'h86);
      run(4, "p4b");
      check("p4_two", uo_out, 8'h5B);

      // Enable hold with a nonzero held count, then resume
      run(2, "pre_hold");
      ena = 1'b0;
      uio_in = 8'($urandom);
      run(20, "hold");
      check("hold_uio", uio_out, 8'h02);
      ena = 1'b1;
      step("resume1");
      check("resume1_uio", uio_out, 8'h02);
      step("resume2");
      check("resume2_uo", uo_out, 8'hCF);

      // Wrap-around with period 1
      do_reset(8'h01);
      run(9, "wrap");
      check("wrap9_uio", uio_out, 8'h09);
      check("wrap9_seg", {1'b0, uo_out[6:0]}, 8'h6F);
      step("wrap10");
      check("wrap10_uio", uio_out, 8'h00);
      check("wrap10_seg", {1'b0, uo_out[6:0]}, 8'h3F);

      // Reset mid-operation at digit 5; next tick a full period later
      do_reset(8'h01);
      run(5, "to5");
      check("at5_uio", uio_out, 8'h05);
      rst = 1'b1;
      step("midrst");
      check("midrst_uo", uo_out, 8'h3F);
      check("midrst_uio", uio_out, 8'h00);
      rst   = 1'b0;
      ui_in = 8'h07;
      run(3, "postrst");
      check("postrst3_uo", uo_out, 8'h3F);
      step("postrst4");
      check("postrst4_uo", uo_out, 8'h86);

      // Period shrink mid-count
      do_reset(8'hFF);
      run(50, "long");
      check("long_uio", uio_out, 8'h00);
      ui_in = 8'h07;
      step("shrink");
      check("shrink_uio", uio_out, 8'h01);
      check("shrink_uo", uo_out, 8'h86);

      // Normal-mode period (reduced MAX_COUNT)
      do_reset(8'h00);
      run(int'(TB_MAX) - 1, "norm_a");
      check("norm_pre", uio_out, 8'h00);
      step("norm_tick");
      check("norm_tick", uio_out, 8'h01);

      // Randomized traffic against the reference model
      for (int i = 0; i < 600; i++) begin
         rst    = ($urandom_range(0, 59) == 0);
         ena    = ($urandom_range(0, 3) != 0);
         uio_in = 8'($urandom);
         if ($urandom_range(0, 19) == 0) begin
            if ($urandom_range(0, 4) == 0)
               ui_in = {7'($urandom), 1'b0};
            else if ($urandom_range(0, 1) == 0)
               ui_in = {4'd0, 3'($urandom), 1'b1};
            else
               ui_in = {7'($urandom), 1'b1};
         end
         step("rand");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule : tb_seven_segment_seconds

`default_nettype wire
